reg_file_mp: RTL

Parametrised multi-port integer register file with write-to-read bypass and an issue scoreboard, for the pipelined RISC-V core. It has NR combinational read ports and NW synchronous write ports, and register 0 is hard-wired to zero. A per-register busy bit is set when an instruction issues to a destination and cleared at writeback, giving the hazard unit a stall signal per read port. It sits between decode/issue (reads, issue) and the writeback stage (writes).

---
 rtl/riscv_pkg.sv | 18 +
 rtl/reg_file_mp_if.sv | 29 ++
 rtl/reg_file_mp_rf_scoreboard.sv | 56 +++++
 rtl/reg_file_mp.sv | 76 +++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared integer-register-file constants and the write-port priority helper.
// No state; pure declarations.
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int ZERO_REG = 0;
    localparam int MAX_NW   = 2;

    // Index of the highest write port whose bit is set; 0 when none set.
    function automatic int wr_prio_sel(input logic [MAX_NW-1:0] hit);
        wr_prio_sel = 0;
        for (int j = 0; j < MAX_NW; j++) begin
            if (hit[j]) wr_prio_sel = j;
        end
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bundle of read, writeback, issue and flush signals for the multi-port register file.
// master = decode/issue + writeback side, slave = register file.
interface reg_file_mp_if #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = 32,
    parameter int NR    = 2,
    parameter int NW    = 1,
    parameter int AW    = $clog2(NREGS)
);
    logic [NR*AW-1:0]   rd_addr;
    logic [NR*XLEN-1:0] rd_data;
    logic [NR-1:0]      rd_busy;
    logic [NW-1:0]      wr_en;
    logic [NW*AW-1:0]   wr_addr;
    logic [NW*XLEN-1:0] wr_data;
    logic               iss_en;
    logic [AW-1:0]      iss_addr;
    logic               flush;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_busy
    );
endinterface

// File: rtl/reg_file_mp_rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback or flush; per-port lookup.
// Latency: busy updates at posedge, rd_busy combinational. No backpressure.
module rf_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int NR    = 2,
    parameter int NW    = 1,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic             flush,
    input  logic [NW-1:0]    wr_en,
    input  logic [NW*AW-1:0] wr_addr,
    input  logic [NR*AW-1:0] rd_addr,
    input  logic [NR-1:0]    byp_hit,
    output logic [NR-1:0]    rd_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Priority: flush, then issue (new producer), then writeback clear.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREGS; r++) begin
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (iss_en && iss_addr == AW'(r)) begin
                busy_d[r] = 1'b1;
            end else begin
                for (int j = 0; j < NW; j++) begin
                    if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(r)) busy_d[r] = 1'b0;
                end
            end
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    // A forwarded write already satisfies the consumer, so it never stalls.
    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NR; k++) begin
            rd_busy[k] = busy_q[rd_addr[k*AW +: AW]] & ~byp_hit[k];
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file, x0 hard-wired to zero, optional write-to-read bypass.
// Latency: reads 0 cycles, writes visible next cycle (same cycle when bypassing). No backpressure.
module reg_file_mp #(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int NREGS  = 32,
    parameter int NR     = 2,
    parameter int NW     = 1,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    reg_file_mp_if.slave  bus
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(riscv_pkg::ZERO_REG);

    logic [XLEN-1:0]               mem [NREGS];
    logic [riscv_pkg::MAX_NW-1:0]  hit [NR];
    logic [NR-1:0]                 byp_hit;
    logic [NR*XLEN-1:0]            rd_data_c;

    // Ascending port order makes the highest-indexed writer win on collisions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) mem[r] <= '0;
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != ZERO_ADDR)
                    mem[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
            end
        end
    end

    // Reads are forced to zero during reset so a forwarded write cannot leak out.
    always_comb begin
        rd_data_c = '0;
        byp_hit   = '0;
        for (int k = 0; k < NR; k++) begin
            hit[k] = '0;
            for (int j = 0; j < NW; j++) begin
                hit[k][j] = bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == bus.rd_addr[k*AW +: AW]);
            end
            if (reset && bus.rd_addr[k*AW +: AW] != ZERO_ADDR) begin
                if (BYPASS != 0 && hit[k] != '0) begin
                    byp_hit[k] = 1'b1;
                    rd_data_c[k*XLEN +: XLEN] =
                        bus.wr_data[riscv_pkg::wr_prio_sel(hit[k])*XLEN +: XLEN];
                end else begin
                    rd_data_c[k*XLEN +: XLEN] = mem[bus.rd_addr[k*AW +: AW]];
                end
            end
        end
    end

    assign bus.rd_data = rd_data_c;

    rf_scoreboard #(
        .NREGS (NREGS),
        .NR    (NR),
        .NW    (NW),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .flush    (bus.flush),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .rd_addr  (bus.rd_addr),
        .byp_hit  (byp_hit),
        .rd_busy  (bus.rd_busy)
    );

endmodule
